lc3_stim_sequencer: RTL

//  Programmable, parametrised stimulus player for the LC-3 top level: replays a stored table of

---
 rtl/lc3_stim_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lc3_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lc3_stim_sequencer
// Brief    : Table-driven switch/button stimulus player with one-shot and
//            looping playback; each entry is held for a programmable count.
// Revision : 1.0  initial release
// ============================================================================
module lc3_stim_sequencer #(
    parameter int SW_W   = 16,
    parameter int NCH    = 3,
    parameter int HOLD_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [SW_W+NCH+HOLD_W-1:0] wr_data,
    input  logic [AW:0]                prog_len,
    input  logic                       loop_mode,
    input  logic                       start,
    input  logic                       stop,
    output logic [SW_W-1:0]            sw_out,
    output logic [NCH-1:0]             btn_n_out,
    output logic                       busy,
    output logic                       done,
    output logic [AW-1:0]              step_idx
);

    localparam int         DW      = SW_W + NCH + HOLD_W;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [DW-1:0]       entry_mem [DEPTH];
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
    logic [AW:0]         play_len, play_len_nx;
    logic                play_loop, play_loop_nx;
    logic [AW-1:0]       step_idx_nx;
    logic [SW_W-1:0]     sw_nx;
    logic [NCH-1:0]      btn_nx;
    logic                done_nx;

    logic                last;
    logic [AW-1:0]       rd_addr;
    logic [SW_W-1:0]     rd_sw;
    logic [NCH-1:0]      rd_btn;
    logic [HOLD_W-1:0]   rd_hold;
    logic [HOLD_W-1:0]   rd_hold_m1;

    // The read port always looks at the entry that would be loaded next:
    // entry 0 from idle or on wrap, otherwise the following step.
    assign last       = ({1'b0, step_idx} == (play_len - LEN_ONE));
    assign rd_addr    = (state == S_PLAY && !last) ? step_idx + AW'(1) : '0;
    assign {rd_sw, rd_btn, rd_hold} = entry_mem[rd_addr];
    assign rd_hold_m1 = (rd_hold == '0) ? '0 : rd_hold - HOLD_W'(1);
    assign busy       = (state == S_PLAY);

    always_ff @(posedge Clk) begin
        if (wr_en && state != S_PLAY) begin
            entry_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            play_len  <= '0;
            play_loop <= 1'b0;
            step_idx  <= '0;
            sw_out    <= '0;
            btn_n_out <= '1;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            play_len  <= play_len_nx;
            play_loop <= play_loop_nx;
            step_idx  <= step_idx_nx;
            sw_out    <= sw_nx;
            btn_n_out <= btn_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        play_len_nx  = play_len;
        play_loop_nx = play_loop;
        step_idx_nx  = step_idx;
        sw_nx        = sw_out;
        btn_nx       = btn_n_out;
        done_nx      = 1'b0;

        case (state)
            S_IDLE: begin
                sw_nx       = '0;
                btn_nx      = '1;
                step_idx_nx = '0;
                hold_cnt_nx = '0;
                if (start && !stop) begin
                    if (prog_len == '0) begin
                        state_nx = S_FINISH;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx     = S_PLAY;
                        play_len_nx  = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                        play_loop_nx = loop_mode;
                        sw_nx        = rd_sw;
                        btn_nx       = rd_btn;
                        hold_cnt_nx  = rd_hold_m1;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_nx    = S_IDLE;
                    sw_nx       = '0;
                    btn_nx      = '1;
                    step_idx_nx = '0;
                    hold_cnt_nx = '0;
                end else if (hold_cnt != '0) begin
                    hold_cnt_nx = hold_cnt - HOLD_W'(1);
                end else if (last && !play_loop) begin
                    state_nx    = S_FINISH;
                    done_nx     = 1'b1;
                    sw_nx       = '0;
                    btn_nx      = '1;
                    step_idx_nx = '0;
                end else begin
                    step_idx_nx = last ? '0 : step_idx + AW'(1);
                    sw_nx       = rd_sw;
                    btn_nx      = rd_btn;
                    hold_cnt_nx = rd_hold_m1;
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
